// File: rtl/regfile_mp_scoreboard.sv
// Multi-port GPR file: NUM_RD combinational read ports, two write-back ports with bypass, per-register pending scoreboard.
// REGFILE_CLEAR_SEQ_EN: when defined, storage is cleared one register per cycle after reset; ready rises when the sweep ends.
module regfile_mp_scoreboard #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter int                NUM_RD  = 2,
  parameter int                SP_IDX  = 29,
  parameter logic [DATA_W-1:0] SP_INIT = 'h7FC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic [ADDR_W:0]            busy_cnt,
  output logic                       ready
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pend_nxt;
  logic              ready_q;
  logic              w0_ok;
  logic              w1_ok;

  assign ready = ready_q & ~reset;

  // wr1 is the later write-back, so it shadows wr0 on an address collision.
  assign w1_ok = ready_q && wr1_en && (wr1_addr != '0);
  assign w0_ok = ready_q && wr0_en && (wr0_addr != '0) && !(wr1_en && (wr1_addr == wr0_addr));

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + (ADDR_W+1)'(v[i]);
    return cnt;
  endfunction

  // A set from a newly issued instruction overrides a same-cycle clear from an older one.
  always_comb begin
    pend_nxt = pending;
    if (ready_q) begin
      if (wr0_en) pend_nxt[wr0_addr] = 1'b0;
      if (wr1_en) pend_nxt[wr1_addr] = 1'b0;
      if (iss_en) pend_nxt[iss_addr] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

`ifdef REGFILE_CLEAR_SEQ_EN
  localparam logic [ADDR_W-1:0] SP_A = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] LAST = '1;

  logic [ADDR_W-1:0] clr_idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!ready_q) begin
        regs[clr_idx] <= (clr_idx == SP_A) ? SP_INIT : '0;
      end else begin
        if (w0_ok) regs[wr0_addr] <= wr0_data;
        if (w1_ok) regs[wr1_addr] <= wr1_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      busy_cnt <= '0;
      ready_q  <= 1'b0;
      clr_idx  <= ADDR_W'(1);
    end else begin
      pending  <= pend_nxt;
      busy_cnt <= popcount(pend_nxt);
      if (!ready_q) begin
        clr_idx <= clr_idx + ADDR_W'(1);
        if (clr_idx == LAST) ready_q <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
    end else begin
      if (w0_ok) regs[wr0_addr] <= wr0_data;
      if (w1_ok) regs[wr1_addr] <= wr1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      busy_cnt <= '0;
      ready_q  <= 1'b0;
    end else begin
      pending  <= pend_nxt;
      busy_cnt <= popcount(pend_nxt);
      ready_q  <= 1'b1;
    end
  end
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit0;
    logic              hit1;

    assign a    = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit1 = wr1_en && (wr1_addr == a);
    assign hit0 = wr0_en && (wr0_addr == a);

    assign rd_data[k*DATA_W +: DATA_W] = (!ready || (a == '0)) ? '0 :
                                         hit1 ? wr1_data :
                                         hit0 ? wr0_data : regs[a];
    assign rd_busy[k] = !ready || ((a != '0) && pending[a] && !hit0 && !hit1);
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Randomised bench for regfile_mp_scoreboard: driver pushes model expectations, a negedge monitor pops and compares.
module tb_regfile_mp_scoreboard;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;
`ifdef REGFILE_CLEAR_SEQ_EN
  localparam int NEED = DEPTH - 1;
`else
  localparam int NEED = 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wr0_en, wr1_en, iss_en;
  logic [AW-1:0]    wr0_addr, wr1_addr, iss_addr;
  logic [DW-1:0]    wr0_data, wr1_data;
  logic [AW:0]      busy_cnt;
  logic             ready;

  regfile_mp_scoreboard dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    busy;
    logic [AW:0]      cnt;
    logic             rdy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  // Reference model: architectural register contents, pending flags, edges since reset.
  logic [DW-1:0] mem [DEPTH];
  bit            pend [DEPTH];
  int            edges;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = (i == 29) ? 32'h0000_07FC : 32'h0;
      pend[i] = 1'b0;
    end
    edges = 0;
  endtask

  task automatic step(input logic rst,
                      input logic w0e, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
                      input logic w1e, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
                      input logic ie,  input logic [AW-1:0] ia,
                      input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    exp_t          e;
    logic          rdy;
    logic [AW-1:0] ra;
    int            cnt;
    @(posedge clk); #1;
    reset = rst; wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
    wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
    iss_en = ie; iss_addr = ia; rd_addr = {r1, r0};

    rdy = !rst && (edges >= NEED);
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) cnt += pend[i] ? 1 : 0;
    e.rdy = rdy;
    e.cnt = (AW+1)'(cnt);
    for (int k = 0; k < NR; k++) begin
      ra = (k == 0) ? r0 : r1;
      if (!rdy) begin
        e.data[k*DW +: DW] = '0;
        e.busy[k] = 1'b1;
      end else if (ra == 0) begin
        e.data[k*DW +: DW] = '0;
        e.busy[k] = 1'b0;
      end else begin
        e.data[k*DW +: DW] = (w1e && w1a == ra) ? w1d : (w0e && w0a == ra) ? w0d : mem[ra];
        e.busy[k] = pend[ra] && !(w0e && w0a == ra) && !(w1e && w1a == ra);
      end
    end
    q.push_back(e);

    if (rst) model_reset();
    else begin
      if (rdy) begin
        if (w0e && w0a != 0) mem[w0a] = w0d;
        if (w1e && w1a != 0) mem[w1a] = w1d;
        if (w0e) pend[w0a] = 1'b0;
        if (w1e) pend[w1a] = 1'b0;
        if (ie && ia != 0) pend[ia] = 1'b1;
      end
      if (edges < 1000) edges++;
    end
  endtask

  task automatic rd(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ready",    64'(ready),    64'(e.rdy));
        check("busy_cnt", 64'(busy_cnt), 64'(e.cnt));
        check("rd_busy",  64'(rd_busy),  64'(e.busy));
        check("rd_data",  rd_data,       e.data);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : driver
    reset = 1'b1; rd_addr = '0;
    wr0_en = 0; wr0_addr = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_data = 0;
    iss_en = 0; iss_addr = 0;
    repeat (2) @(posedge clk);
    model_reset();

    // Not-ready window: writes and issues must be ignored.
    for (int i = 0; i < NEED; i++)
      step(0, 1, 5'd6, 32'hDEAD_0000 + i, 1, 5'd29, 32'hBAD, 1, 5'd6, 5'd6, 5'd29);

    for (int a = 0; a < DEPTH; a += 2) rd(AW'(a), AW'(a + 1));
    step(0, 1, 5'd0, 32'h5, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    rd(5'd0, 5'd0);

    step(0, 1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 0, 0, 5'd3, 5'd3);
    rd(5'd3, 5'd0);

    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0);
    rd(5'd7, 5'd7);
    step(0, 1, 5'd7, 32'hAB, 0, 0, 0, 0, 0, 5'd7, 5'd7);
    rd(5'd7, 5'd0);

    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0);
    step(0, 0, 0, 0, 1, 5'd9, 32'h99, 1, 5'd9, 5'd9, 5'd9);
    rd(5'd9, 5'd9);

    step(0, 1, 5'd4, 32'h5, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0);
    step(1, 1, 5'd4, 32'h77, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0);
    for (int i = 0; i < NEED; i++) rd(5'd4, 5'd29);
    rd(5'd4, 5'd29);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0,
           1'($urandom), raddr(), $urandom,
           1'($urandom), raddr(), $urandom,
           1'($urandom), raddr(),
           raddr(), raddr());

    @(negedge clk);
    @(negedge clk);
    check("queue_drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
